// File: rtl/garduino_pio_pkg.sv
// Shared definitions for the garduino PIO blocks.
//   - Avalon-MM word addresses of the input-port register map
//   - Edge-capture type encodings
package garduino_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_DEBOUNCE = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  typedef enum int unsigned {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_type_e;

endpackage

// File: rtl/garduino_sys_v1_in_sync_db.sv
// Input conditioning for the sensor input port: 2-flop synchronizer, debounce
// prescaler and per-bit debouncer.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   in_port_i     : asynchronous external pins
//   db_period_i   : current DEBOUNCE register value (0 = bypass)
//   db_wval_i     : DEBOUNCE value being written this cycle
//   db_load_i     : DEBOUNCE write strobe, reloads the prescaler from db_wval_i
//   debounced_o   : debounced pin state
module garduino_sys_v1_in_sync_db
  import garduino_pio_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DB_W     = 16,
  parameter int unsigned DB_RESET = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port_i,
  input  logic [DB_W-1:0]  db_period_i,
  input  logic [DB_W-1:0]  db_wval_i,
  input  logic             db_load_i,
  output logic [WIDTH-1:0] debounced_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [DB_W-1:0]  presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] same;

  assign tick = (presc_q == '0);
  assign same = ~(sync2_q ^ samp_q);

  always_comb begin
    presc_d = presc_q - DB_W'(1);
    if (db_load_i) begin
      presc_d = db_wval_i;
    end else if (tick) begin
      presc_d = db_period_i;
    end
  end

  // A bit only follows sync2 when it matched the sample from the previous tick,
  // so a change has to be stable across two consecutive ticks.
  always_comb begin
    samp_d = samp_q;
    db_d   = db_q;
    if (db_period_i == '0) begin
      samp_d = sync2_q;
      db_d   = sync2_q;
    end else if (tick) begin
      samp_d = sync2_q;
      db_d   = (db_q & ~same) | (sync2_q & same);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      db_q    <= '0;
      presc_q <= DB_W'(DB_RESET);
    end else begin
      sync1_q <= in_port_i;
      sync2_q <= sync1_q;
      samp_q  <= samp_d;
      db_q    <= db_d;
      presc_q <= presc_d;
    end
  end

  assign debounced_o = db_q;

endmodule

// File: rtl/garduino_sys_v1_sensor_inputs.sv
// Avalon-MM slave sensor input port with debounce, edge capture and a maskable
// level interrupt.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata     : Avalon-MM slave write side
//   readdata               : combinational read data (zero wait states)
//   in_port                : asynchronous external pins
//   irq                    : level interrupt, |(EDGECAP & IRQMASK)
module garduino_sys_v1_sensor_inputs
  import garduino_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DB_W      = 16,
  parameter int unsigned DB_RESET  = 50000,
  parameter edge_type_e  EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic             wr;
  logic [DB_W-1:0]  dbreg_q, dbreg_d;
  logic             db_load;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] rise, fall, sel;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = &{1'b0, writedata};

  garduino_sys_v1_in_sync_db #(
    .WIDTH    (WIDTH),
    .DB_W     (DB_W),
    .DB_RESET (DB_RESET)
  ) u_sync_db (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_port_i   (in_port),
    .db_period_i (dbreg_q),
    .db_wval_i   (dbreg_d),
    .db_load_i   (db_load),
    .debounced_o (debounced)
  );

  always_comb begin
    dbreg_d = dbreg_q;
    mask_d  = mask_q;
    clr     = '0;
    db_load = 1'b0;
    if (wr) begin
      case (address)
        ADDR_DEBOUNCE: begin
          dbreg_d = writedata[DB_W-1:0];
          db_load = 1'b1;
        end
        ADDR_IRQMASK: mask_d = writedata[WIDTH-1:0];
        ADDR_EDGECAP: clr    = writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign rise = debounced & ~prev_q;
  assign fall = ~debounced & prev_q;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: sel = fall;
      EDGE_ANY:  sel = rise | fall;
      default:   sel = rise;
    endcase
  end

  // OR-ing sel after the clear makes a new edge win over a same-cycle W1C.
  assign ecap_d = (ecap_q & ~clr) | sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbreg_q <= DB_W'(DB_RESET);
      mask_q  <= '0;
      ecap_q  <= '0;
      prev_q  <= '0;
    end else begin
      dbreg_q <= dbreg_d;
      mask_q  <= mask_d;
      ecap_q  <= ecap_d;
      prev_q  <= debounced;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0] = debounced;
      ADDR_DEBOUNCE: readdata[DB_W-1:0]  = dbreg_q;
      ADDR_IRQMASK:  readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP:  readdata[WIDTH-1:0] = ecap_q;
      default:       readdata = '0;
    endcase
  end

  assign irq = |(ecap_q & mask_q);

endmodule
